pucch_bit_scrambler: RTL and testbench
======================================

// Module: pucch_bit_scrambler
// PURPOSE
//  Scrambles a PUCCH payload bit stream with the Gold sequence c(i): b~(i) = b(i) ^ c(i).
//  Sits directly downstream of c_seq_gen and drives its i_en/i_load/i_init ports.
//  Pulls payload words over a valid/ready stream, aligns them to c-sequence words, and emits
//  scrambled words with backpressure. Feeds the modulation mapper.
// PARAMETERS
//  nGenBit    8    bits per word; must match c_seq_gen nGenBit; bit 0 = lowest index i
//  NUM_BIT_W  16   width of the M_bit count
// PORTS
//  clk            in   1          single clock
//  rst_n          in   1          synchronous reset, active-low
//  i_start        in   1          1-cycle pulse: begin a codeword; sampled only in IDLE
//  i_c_init       in   31         c_init for this codeword; captured on i_start
//  i_num_bits     in   NUM_BIT_W  M_bit; captured on i_start
//  i_abort        in   1          synchronous flush to IDLE
//  s_data         in   nGenBit    payload word
//  s_valid        in   1          payload word valid
//  s_ready        out  1          payload word accepted when s_valid & s_ready
//  m_data         out  nGenBit    scrambled word; bits >= remaining M_bit forced to 0
//  m_valid        out  1          output word valid
//  m_last         out  1          qualifies the final word of the codeword
//  m_ready        in   1          downstream ready
//  o_cgen_en      out  1          request next c word from c_seq_gen
//  o_cgen_load    out  1          load c_seq_gen with o_cgen_init; also yields word 0
//  o_cgen_init    out  31         registered copy of i_c_init
//  i_cgen_seq     in   nGenBit    c_seq_gen o_seq_bit
//  i_cgen_valid   in   1          c_seq_gen o_valid; fixed 1-cycle latency after en/load
//  o_busy         out  1          high outside IDLE
//  o_done         out  1          1-cycle pulse after the m_last word is accepted
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; s_ready, m_valid, m_last, o_cgen_en,
//    o_cgen_load, o_busy, o_done = 0; m_data, o_cgen_init = 0; counters and buffers cleared.
//  - Word count: N_w = ceil(M_bit/nGenBit). If M_bit = 0, i_start pulses o_done the next cycle
//    and produces no words or c_seq_gen requests.
//  - FSM IDLE->LOAD (i_start, M_bit>0) -> RUN -> DRAIN -> IDLE.
//    - LOAD: one cycle with o_cgen_load = 1; counts as one outstanding request.
//    - RUN: o_cgen_en = 1 while (c_fifo_occupancy + in_flight) < 2 and requests < N_w.
//      After N_w requests, no further requests.
//  - c_fifo: 2 entries; written on i_cgen_valid. If i_cgen_valid arrives with the fifo full,
//    that is a protocol error; the credit rule above guarantees it cannot happen.
//  - s_ready = RUN & c_fifo non-empty & (~m_valid | m_ready) & words_in < N_w.
//    On accept, m_data <= s_data ^ c_head and the c_fifo pops.
//    Output register: latency is 1 cycle from s accept to m_valid.
//  - Final word: m_data bits [nGenBit-1 : M_bit mod nGenBit] are 0 when the mod is nonzero;
//    m_last = 1. RUN->DRAIN after the final accept. DRAIN->IDLE when m_valid & m_ready,
//    with o_done pulsed that same transition.
//  - Sustained throughput: 1 word/clk with s_valid and m_ready both held high.
//  - m_valid/m_data/m_last hold stable while m_valid & ~m_ready.
//  - i_start outside IDLE is ignored.
//  - i_abort (any state): next cycle IDLE, buffers cleared, m_valid = 0, no o_done.
//    If i_abort and i_start are both high in IDLE, i_abort wins.
//  - i_cgen_valid seen in IDLE (stale after abort) is dropped.
//    A new LOAD restarts c_seq_gen from word 0 regardless.
// CONFIGURATION
//  PUCCH_SCR_BYPASS_EN defined: adds input port i_bypass (1 bit, captured on i_start).
//    When captured high: no o_cgen_load/o_cgen_en issued; m_data = s_data with tail masking;
//    handshakes, m_last and o_done unchanged.
//  Undefined: no i_bypass port; scrambling always applied.
// TESTING (nGenBit=8, ref model = bit-exact c(i) generator)
//  T1: c_init=0x1234, M_bit=32, s_data=0x00, m_ready=1
//      -> m_data = c words 0..3 in order; m_last on 4th word; o_done 1 cycle later.
//  T2: M_bit=20, s_data=0xFF
//      -> 3 words; word2 = (~c[16:23]) & 0x0F; m_last on word2.
//  T3: M_bit=64, m_ready toggling 1010..., random s_valid stalls
//      -> output matches model; m_data stable while stalled; never more than 2 outstanding c
//         requests.
//  T4: M_bit=0 -> o_done 1 cycle after i_start; no m_valid, no o_cgen_load.
//  T5: i_abort after 3 of 8 words; restart with M_bit=16
//      -> first output = word 0 of the new c_init, no o_done for the aborted codeword.
//  T6: rst_n low mid-RUN
//      -> all outputs 0 next cycle; back-to-back i_start after o_done accepted in IDLE.

Source files
------------

// File: rtl/pucch_bit_scrambler.sv
// PUCCH payload bit scrambler: b~(i) = b(i) ^ c(i), with c(i) pulled word-wise from c_seq_gen.
// Optional build macro PUCCH_SCR_BYPASS_EN adds i_bypass (captured on i_start), which
// skips c_seq_gen traffic and passes payload through with tail masking only.
module pucch_bit_scrambler #(
  parameter int nGenBit   = 8,
  parameter int NUM_BIT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [30:0]          i_c_init,
  input  logic [NUM_BIT_W-1:0] i_num_bits,
  input  logic                 i_abort,
`ifdef PUCCH_SCR_BYPASS_EN
  input  logic                 i_bypass,
`endif
  input  logic [nGenBit-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [nGenBit-1:0]   m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 o_cgen_en,
  output logic                 o_cgen_load,
  output logic [30:0]          o_cgen_init,
  input  logic [nGenBit-1:0]   i_cgen_seq,
  input  logic                 i_cgen_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int TW = (nGenBit > 1) ? $clog2(nGenBit) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_BIT_W-1:0]   nw_q, req_q, win_q;
  logic [TW-1:0]          tail_q;
  logic [30:0]            cinit_q;
  logic                   inflt_q;
  logic [nGenBit-1:0]     fifo_q [2];
  logic                   wptr_q, rptr_q;
  logic [1:0]             cnt_q;
  logic [nGenBit-1:0]     mdata_q;
  logic                   mvalid_q, mlast_q, done_q;
  logic                   byp_q;

  logic                   run, accept, pop, push, last_word, cgen_en, cgen_load;
  logic [2:0]             occ;
  logic [nGenBit-1:0]     c_head, mask, word_d;

`ifdef PUCCH_SCR_BYPASS_EN
  // Bypass selection is latched per codeword
  always_ff @(posedge clk) begin
    if (!rst_n)                                    byp_q <= 1'b0;
    else if (state_q == IDLE && i_start && !i_abort) byp_q <= i_bypass;
  end
`else
  assign byp_q = 1'b0;
`endif

  // Datapath handshakes, c-word credit and final-word masking
  always_comb begin
    run       = (state_q == RUN);
    s_ready   = run && (byp_q || cnt_q != 2'd0) && (!mvalid_q || m_ready) && (win_q < nw_q);
    accept    = s_valid && s_ready;
    pop       = accept && !byp_q;
    push      = i_cgen_valid && (state_q != IDLE) && (cnt_q != 2'd2);
    last_word = (win_q == nw_q - NUM_BIT_W'(1));
    c_head    = byp_q ? '0 : fifo_q[rptr_q];
    for (int b = 0; b < nGenBit; b++) mask[b] = (tail_q == '0) || (TW'(b) < tail_q);
    word_d    = (s_data ^ c_head) & (last_word ? mask : '1);
    // occupancy after this cycle's pop plus the request still in flight
    occ       = 3'(cnt_q) + 3'(inflt_q) - 3'(pop);
    cgen_load = (state_q == LOAD) && !byp_q && !i_abort;
    cgen_en   = run && !byp_q && !i_abort && (occ < 3'd2) && (req_q < nw_q);
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start && i_num_bits != '0) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (accept && last_word) state_d = DRAIN;
      DRAIN:   if (mvalid_q && m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) state_d = IDLE;
  end

  // State, codeword parameters, request/word counters and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nw_q    <= '0;
      req_q   <= '0;
      win_q   <= '0;
      tail_q  <= '0;
      cinit_q <= '0;
      inflt_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (i_abort) begin
        req_q   <= '0;
        win_q   <= '0;
        inflt_q <= 1'b0;
      end else begin
        inflt_q <= cgen_load || cgen_en;
        if (cgen_load || cgen_en) req_q <= req_q + NUM_BIT_W'(1);
        if (accept)               win_q <= win_q + NUM_BIT_W'(1);
        if (state_q == IDLE && i_start) begin
          cinit_q <= i_c_init;
          nw_q    <= (i_num_bits - NUM_BIT_W'(1)) / NUM_BIT_W'(nGenBit) + NUM_BIT_W'(1);
          tail_q  <= TW'(i_num_bits % NUM_BIT_W'(nGenBit));
          req_q   <= '0;
          win_q   <= '0;
          if (i_num_bits == '0) done_q <= 1'b1;
        end
        if (state_q == DRAIN && mvalid_q && m_ready) done_q <= 1'b1;
      end
    end
  end

  // Two-entry c-word FIFO; stale words arriving in IDLE are dropped
  always_ff @(posedge clk) begin
    if (!rst_n || i_abort) begin
      for (int e = 0; e < 2; e++) fifo_q[e] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= i_cgen_seq;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  // Output register; holds while stalled by m_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end else if (i_abort) begin
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end else if (accept) begin
      mdata_q  <= word_d;
      mvalid_q <= 1'b1;
      mlast_q  <= last_word;
    end else if (m_ready) begin
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end
  end

  assign m_data      = mdata_q;
  assign m_valid     = mvalid_q;
  assign m_last      = mlast_q;
  assign o_cgen_en   = cgen_en;
  assign o_cgen_load = cgen_load;
  assign o_cgen_init = cinit_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;

endmodule

// File: tb/tb_pucch_bit_scrambler.sv
// Directed bench for pucch_bit_scrambler with a behavioural c_seq_gen and Gold-sequence model.
module tb_pucch_bit_scrambler;

  logic        clk = 1'b0;
  logic        rst_n, i_start, i_abort, s_valid, m_ready;
  logic [30:0] i_c_init;
  logic [15:0] i_num_bits;
  logic [7:0]  s_data;
  logic        s_ready, m_valid, m_last, o_cgen_en, o_cgen_load, o_busy, o_done;
  logic [7:0]  m_data;
  logic [30:0] o_cgen_init;
  logic [7:0]  cg_seq;
  logic        cg_valid;
  logic [30:0] cg_init;
  int          cg_ptr;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, load_cnt = 0, en_cnt = 0;
  int done_cyc = 0, last_hs_cyc = 0, outst = 0, max_outst = 0, stall_viol = 0;
  logic [7:0]  out_d[$];
  bit          out_l[$];
  int          out_c[$];
  bit          stall_prev = 0;
  logic [7:0]  stall_d;
  bit          stall_l;

  always #5 clk = ~clk;

  pucch_bit_scrambler #(.nGenBit(8), .NUM_BIT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_c_init(i_c_init),
    .i_num_bits(i_num_bits), .i_abort(i_abort),
`ifdef PUCCH_SCR_BYPASS_EN
    .i_bypass(1'b0),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .o_cgen_en(o_cgen_en), .o_cgen_load(o_cgen_load), .o_cgen_init(o_cgen_init),
    .i_cgen_seq(cg_seq), .i_cgen_valid(cg_valid), .o_busy(o_busy), .o_done(o_done));

  // Gold sequence c(n) = x1(n+1600) ^ x2(n+1600); returns c(8k..8k+7), bit 0 = lowest index
  function automatic logic [7:0] cword(input logic [30:0] ci, input int k);
    bit x1[0:1799];
    bit x2[0:1799];
    logic [7:0] w;
    int top;
    top = 1600 + 8*k + 8;
    for (int n = 0; n < 31; n++) begin x1[n] = (n == 0); x2[n] = ci[n]; end
    for (int n = 0; n + 31 < top; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int b = 0; b < 8; b++) w[b] = x1[1600+8*k+b] ^ x2[1600+8*k+b];
    return w;
  endfunction

  // Behavioural c_seq_gen: one-cycle latency, load yields word 0
  always @(posedge clk) begin
    if (!rst_n) begin
      cg_valid <= 1'b0; cg_seq <= '0; cg_ptr <= 0; cg_init <= '0;
    end else if (o_cgen_load) begin
      cg_init <= o_cgen_init; cg_seq <= cword(o_cgen_init, 0); cg_ptr <= 1; cg_valid <= 1'b1;
    end else if (o_cgen_en) begin
      cg_seq <= cword(cg_init, cg_ptr); cg_ptr <= cg_ptr + 1; cg_valid <= 1'b1;
    end else cg_valid <= 1'b0;
  end

  // Monitor: handshakes, pulses, outstanding requests, stall stability
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      outst = 0; stall_prev = 0;
    end else begin
      if (stall_prev && !i_abort &&
          (m_valid !== 1'b1 || m_data !== stall_d || m_last !== stall_l)) stall_viol++;
      stall_prev = m_valid && !m_ready;
      stall_d = m_data; stall_l = m_last;
      if (s_valid && s_ready) acc_cnt++;
      if (m_valid && m_ready) begin
        out_d.push_back(m_data); out_l.push_back(m_last); out_c.push_back(cyc); last_hs_cyc = cyc;
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_cgen_load) load_cnt++;
      if (o_cgen_en) en_cnt++;
      if (i_abort) outst = 0;
      else outst = outst + int'(o_cgen_load) + int'(o_cgen_en) - int'(s_valid && s_ready);
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one codeword; stop_after >= 0 returns early once that many words came out
  task automatic run_cw(input logic [30:0] ci, input int m, input logic [7:0] pat,
                        input logic [7:0] step, input bit stress, input int stop_after);
    int nw, ab, ob, db, idx;
    bit fin;
    logic [7:0] exp, msk;
    nw = (m + 7) / 8; ab = acc_cnt; ob = out_d.size(); db = done_cnt;
    i_c_init = ci; i_num_bits = 16'(m); i_start = 1'b1;
    tick;
    i_start = 1'b0;
    fin = 0;
    for (int cy = 0; cy < 600 && !fin; cy++) begin
      idx = acc_cnt - ab;
      if (stop_after >= 0 && out_d.size() - ob >= stop_after) fin = 1;
      else if (done_cnt != db) fin = 1;
      else begin
        s_data  = pat + 8'(idx) * step;
        s_valid = (idx < nw) && (!stress || $urandom_range(0, 3) != 0);
        m_ready = !stress || cy[0];
        tick;
      end
    end
    s_valid = 1'b0; m_ready = 1'b1;
    if (stop_after < 0) begin
      chk("done_count", done_cnt - db, 1);
      chk("word_count", out_d.size() - ob, nw);
      for (int k = 0; k < nw && ob + k < out_d.size(); k++) begin
        exp = (pat + 8'(k) * step) ^ cword(ci, k);
        msk = 8'hFF;
        if (k == nw - 1 && (m % 8) != 0) msk = 8'hFF >> (8 - (m % 8));
        chk($sformatf("word%0d_data", k), out_d[ob+k], exp & msk);
        chk($sformatf("word%0d_last", k), out_l[ob+k], (k == nw - 1));
      end
    end else chk("partial_words", out_d.size() - ob >= stop_after, 1);
  endtask

  initial begin
    int ob, lc, ec, db, vc;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    i_c_init = '0; i_num_bits = '0; s_data = '0;
    tick; tick;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_cgen_en", o_cgen_en, 0);
    chk("rst_cgen_load", o_cgen_load, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_cgen_init", o_cgen_init, 0);
    rst_n = 1'b1;
    tick;

    // T1: zero payload exposes c words directly, full rate
    ob = out_d.size(); lc = load_cnt; ec = en_cnt;
    run_cw(31'h1234, 32, 8'h00, 8'h00, 0, -1);
    chk("t1_init_reg", o_cgen_init, 31'h1234);
    chk("t1_throughput", out_c[ob+3] - out_c[ob], 3);
    chk("t1_done_latency", done_cyc - last_hs_cyc, 1);
    chk("t1_loads", load_cnt - lc, 1);
    chk("t1_ens", en_cnt - ec, 3);

    // T2: partial tail word is masked
    ob = out_d.size();
    run_cw(31'h5A5A5, 20, 8'hFF, 8'h00, 0, -1);
    chk("t2_word2", out_d[ob+2], (~cword(31'h5A5A5, 2)) & 8'h0F);

    // T3: backpressure and input stalls
    run_cw(31'h7ABCDEF, 64, 8'h21, 8'h37, 1, -1);
    chk("t3_stable", stall_viol, 0);
    chk("t3_outstanding", max_outst <= 2, 1);

    // T4: empty codeword
    lc = load_cnt; vc = out_d.size();
    i_num_bits = '0; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("t4_done", o_done, 1);
    chk("t4_busy", o_busy, 0);
    tick;
    chk("t4_done_pulse", o_done, 0);
    tick; tick;
    chk("t4_no_load", load_cnt - lc, 0);
    chk("t4_no_words", out_d.size() - vc, 0);
    chk("t4_m_valid", m_valid, 0);

    // T5: abort mid-codeword, then restart on a new c_init
    db = done_cnt;
    run_cw(31'h0BEEF, 64, 8'h55, 8'h01, 0, 3);
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_busy", o_busy, 0);
    tick; tick; tick;
    chk("t5_no_done", done_cnt - db, 0);
    i_abort = 1'b1; i_start = 1'b1; i_num_bits = 16'd8;
    tick;
    i_abort = 1'b0; i_start = 1'b0;
    chk("t5_abort_wins", o_busy, 0);
    tick; tick;
    ob = out_d.size();
    run_cw(31'h13579, 16, 8'h3C, 8'h01, 0, -1);
    chk("t5_first_word", out_d[ob], 8'h3C ^ cword(31'h13579, 0));

    // T6: reset mid-RUN, then back-to-back codewords
    run_cw(31'h2468A, 64, 8'h00, 8'h01, 0, 2);
    rst_n = 1'b0;
    tick;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_s_ready", s_ready, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_cgen_en", o_cgen_en, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_cgen_init", o_cgen_init, 0);
    rst_n = 1'b1;
    tick;
    run_cw(31'h600D, 8, 8'hA5, 8'h00, 0, -1);
    run_cw(31'h7FFFFFFF, 24, 8'h0F, 8'h10, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
